// File: rtl/sd_mem1p_rdq.sv
// rtl/sd_mem1p_rdq.sv - single-port RAM behind a srdy/drdy command channel with a 3-entry read response queue
// Optional: define SD_MEM1P_INIT_EN to zero-fill the array after every reset before accepting commands.

module sd_mem1p_rdq #(
  parameter int depth   = 256,
  parameter int width   = 32,
  parameter int addr_sz = $clog2(depth),
  parameter int mask_sz = width / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic               c_wr,
  input  logic [addr_sz-1:0] c_addr,
  input  logic [width-1:0]   c_data,
  input  logic [mask_sz-1:0] c_mask,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
  output logic               init_done
);

  localparam logic [addr_sz:0] DEPTH_W = (addr_sz + 1)'(depth);

  logic [width-1:0]   mem [depth];
  logic [width-1:0]   q_data_q [3];
  logic [1:0]         count_q, count_d;
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic               inflight_q;
  logic [addr_sz-1:0] rd_addr_q;
  logic               init_done_q;

  logic               c_xfer, rd_xfer, wr_xfer;
  logic               c_in_range, rd_in_range;
  logic               push, pop;
  logic [width-1:0]   rd_word;
  logic               mem_we;
  logic [addr_sz-1:0] mem_waddr;
  logic [width-1:0]   mem_wdata;
  logic [mask_sz-1:0] mem_wmask;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check counts the read already in flight so the queue can never overflow.
  assign c_drdy  = init_done_q & (({1'b0, count_q} + {2'b0, inflight_q}) < 3'd3);
  assign c_xfer  = c_srdy & c_drdy;
  assign rd_xfer = c_xfer & ~c_wr;
  assign wr_xfer = c_xfer & c_wr;

  assign c_in_range  = {1'b0, c_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr_q} < DEPTH_W;
  assign rd_word     = rd_in_range ? mem[rd_addr_q] : '0;

  assign push      = inflight_q;
  assign pop       = p_srdy & p_drdy;
  assign p_srdy    = (count_q != 2'd0);
  assign p_data    = q_data_q[rd_ptr_q];
  assign init_done = init_done_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      inflight_q <= 1'b0;
      rd_addr_q  <= '0;
      for (int i = 0; i < 3; i++) q_data_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= rd_xfer;
      if (rd_xfer) rd_addr_q <= c_addr;
      if (push) begin
        q_data_q[wr_ptr_q] <= rd_word;
        wr_ptr_q           <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

`ifdef SD_MEM1P_INIT_EN
  localparam logic [addr_sz-1:0] LAST_A = addr_sz'(depth - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;
  state_t             state_q;
  logic [addr_sz-1:0] init_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_addr_q == LAST_A) begin
            state_q     <= ST_READY;
            init_addr_q <= '0;
            init_done_q <= 1'b1;
          end else begin
            init_addr_q <= init_addr_q + 1'b1;
          end
        end
        default: state_q <= ST_READY;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) init_done_q <= 1'b0;
    else       init_done_q <= 1'b1;
  end
`endif

  always_comb begin
    mem_we    = wr_xfer & c_in_range;
    mem_waddr = c_addr;
    mem_wdata = c_data;
    mem_wmask = c_mask;
`ifdef SD_MEM1P_INIT_EN
    if (state_q == ST_INIT && !reset) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end
`endif
  end

  // The array itself is never reset; only the sweep above clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < mask_sz; i++) begin
        if (mem_wmask[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sd_mem1p_rdq.sv
// tb/tb_sd_mem1p_rdq.sv - randomized self-checking bench for sd_mem1p_rdq against a queue-level model
module tb_sd_mem1p_rdq;

`ifdef SD_MEM1P_INIT_EN
  localparam int DEPTH    = 16;
  localparam int INIT_CYC = 16;
`else
  localparam int DEPTH    = 200;
  localparam int INIT_CYC = 1;
`endif
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          c_srdy = 1'b0, c_wr = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [31:0]   c_data = '0;
  logic [3:0]    c_mask = '0;
  logic          p_drdy = 1'b0;
  logic          c_drdy, p_srdy, init_done;
  logic [31:0]   p_data;

  sd_mem1p_rdq #(.depth(DEPTH), .width(32)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_wr(c_wr), .c_addr(c_addr),
    .c_data(c_data), .c_mask(c_mask),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  bit [31:0] mm [DEPTH];
  bit [31:0] vis[$];
  bit [31:0] got[$];
  bit        pend_v;
  bit [31:0] pend_d;
  int        cyc;
  int        errors = 0, checks = 0;
  bit        acc;
  int        n, nxt, nacc, issued;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic bit exp_drdy();
    return (cyc >= INIT_CYC) && ((vis.size() + int'(pend_v)) < 3);
  endfunction

  task automatic check_outputs();
    chk("c_drdy", c_drdy, exp_drdy());
    chk("init_done", init_done, cyc >= INIT_CYC);
    chk("p_srdy", p_srdy, vis.size() != 0);
    if (vis.size() != 0) chk("p_data", p_data, vis[0]);
  endtask

  task automatic step(input bit srdy, input bit wr, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] m, input bit pd, output bit ok);
    bit ed;
    int ai;
    ed = exp_drdy();
    ai = int'(a);
    c_srdy = srdy; c_wr = wr; c_addr = a; c_data = d; c_mask = m; p_drdy = pd;
    if (p_srdy && pd) got.push_back(p_data);
    @(posedge clk);
    ok = srdy && ed;
    if (vis.size() != 0 && pd) void'(vis.pop_front());
    if (pend_v) vis.push_back(pend_d);
    pend_v = ok && !wr;
    if (pend_v) begin
      if (ai < DEPTH) pend_d = mm[ai];
      else            pend_d = 32'h0;
    end
    if (ok && wr && ai < DEPTH)
      for (int i = 0; i < 4; i++) if (m[i]) mm[ai][8*i +: 8] = d[8*i +: 8];
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit pd);
    bit ok;
    step(1'b0, 1'b0, '0, 32'h0, 4'h0, pd, ok);
  endtask

  task automatic put_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    bit ok;
    int k;
    ok = 0;
    for (k = 0; k < 20 && !ok; k++) step(1'b1, 1'b1, a, d, m, 1'b1, ok);
    if (!ok) fail_now("put_wr");
  endtask

  task automatic put_rd(input logic [AW-1:0] a, input bit pd);
    bit ok;
    int k;
    ok = 0;
    for (k = 0; k < 20 && !ok; k++) step(1'b1, 1'b0, a, 32'h0, 4'h0, pd, ok);
    if (!ok) fail_now("put_rd");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((vis.size() != 0 || pend_v) && k < 50) begin
      idle(1'b1);
      k++;
    end
    if (k >= 50) fail_now("drain");
  endtask

  task automatic do_reset(input int ncyc);
    #2;
    reset = 1'b1; c_srdy = 1'b0; p_drdy = 1'b0;
    #1;
    chk("rst_p_srdy", p_srdy, 1'b0);
    chk("rst_p_data", p_data, 32'h0);
    chk("rst_c_drdy", c_drdy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    vis.delete();
    pend_v = 0;
    cyc = 0;
`ifdef SD_MEM1P_INIT_EN
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
`endif
    repeat (ncyc) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    do begin
      idle(1'b0);
      cnt++;
    end while (!init_done && cnt < 100);
  endtask

  initial begin
    pend_v = 0;
    cyc = 0;
    do_reset(2);
    wait_init(n);
    chk("init_latency", n, INIT_CYC);

`ifdef SD_MEM1P_INIT_EN
    repeat (7) idle(1'b0);
    do_reset(1);
    wait_init(n);
    chk("init_restart", n, INIT_CYC);
    got.delete();
    for (int a = 0; a < DEPTH; a++) put_rd(AW'(a), 1'b1);
    drain();
    chk("zero_count", got.size(), DEPTH);
    for (int i = 0; i < got.size(); i++) chk("zero_data", got[i], 32'h0);
`endif

    for (int a = 0; a < DEPTH; a++) put_wr(AW'(a), $urandom, 4'hF);
    for (int a = 0; a < 16; a++) put_wr(AW'(a), 32'(a * 3), 4'hF);

    // full write then read-after-write with 1-cycle latency
    put_wr(AW'(5), 32'hDEADBEEF, 4'hF);
    step(1'b1, 1'b0, AW'(5), 32'h0, 4'h0, 1'b0, acc);
    chk("raw_acc", acc, 1'b1);
    chk("lat_edge_n", p_srdy, 1'b0);
    idle(1'b0);
    chk("lat_edge_n1", p_srdy, 1'b1);
    chk("rd5_full", p_data, 32'hDEADBEEF);
    idle(1'b1);

    put_wr(AW'(5), 32'h11223344, 4'h5);
    step(1'b1, 1'b0, AW'(5), 32'h0, 4'h0, 1'b0, acc);
    idle(1'b0);
    chk("rd5_masked", p_data, 32'hDE22BE44);
    put_wr(AW'(5), 32'h0, 4'h0);
    drain();
    put_wr(AW'(5), 32'd15, 4'hF);
    drain();

    // back-pressure: only three reads fit
    got.delete();
    nxt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, AW'(nxt), 32'h0, 4'h0, 1'b0, acc);
      if (acc) nxt++;
    end
    chk("bp_accepted", nxt, 3);
    chk("bp_c_drdy", c_drdy, 1'b0);
    n = 0;
    while ((nxt < 6 || vis.size() != 0 || pend_v) && n < 50) begin
      if (nxt < 6) begin
        step(1'b1, 1'b0, AW'(nxt), 32'h0, 4'h0, 1'b1, acc);
        if (acc) nxt++;
      end else idle(1'b1);
      n++;
    end
    chk("bp_resp_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++) chk("bp_order", got[i], 32'(i * 3));

    // back-to-back reads with consumer always ready
    got.delete();
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, AW'(i), 32'h0, 4'h0, 1'b1, acc);
      nacc += int'(acc);
    end
    chk("b2b_accepted", nacc, 16);
    chk("b2b_resp_streaming", got.size(), 14);
    idle(1'b1);
    idle(1'b1);
    chk("b2b_resp_total", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("b2b_order", got[i], 32'(i * 3));

`ifndef SD_MEM1P_INIT_EN
    put_wr(AW'(210), 32'hFFFFFFFF, 4'hF);
    step(1'b1, 1'b0, AW'(210), 32'h0, 4'h0, 1'b0, acc);
    idle(1'b0);
    chk("oor_read", p_data, 32'h0);
    drain();
`endif

    // randomized mix with random consumer stalls
    issued = 0;
    n = 0;
    while (issued < 2000 && n < 30000) begin
      logic [3:0] m;
      m = (($urandom % 10) == 0) ? 4'h0 : 4'($urandom);
      step(($urandom % 4) != 0, $urandom % 2, AW'($urandom), $urandom, m, $urandom % 2, acc);
      issued += int'(acc);
      n++;
    end
    if (issued < 2000) fail_now("random_cmds");
    drain();

    // reset in the middle of buffered responses
    put_wr(AW'(7), 32'hA5A50007, 4'hF);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, AW'(i), 32'h0, 4'h0, 1'b0, acc);
    idle(1'b0);
    chk("pre_rst_p_srdy", p_srdy, 1'b1);
    do_reset(2);
    wait_init(n);
    chk("init_latency_2", n, INIT_CYC);
    step(1'b1, 1'b0, AW'(7), 32'h0, 4'h0, 1'b0, acc);
    idle(1'b0);
`ifdef SD_MEM1P_INIT_EN
    chk("mem_after_rst", p_data, 32'h0);
`else
    chk("mem_after_rst", p_data, 32'hA5A50007);
`endif
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
